// File: rtl/mem_controller_if.sv
// Bus bundle for the data-memory controller: the LSU-facing ask/get ports
// and the memory-facing channel ports. The controller uses the slave view;
// the surrounding cores and memory together use the master view.
interface mem_controller_if #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 4
);
    // LSU side
    logic [NUM_CONSUMERS-1:0]                consumer_read_ask;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_addr;
    logic [NUM_CONSUMERS-1:0]                consumer_read_get;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
    logic [NUM_CONSUMERS-1:0]                consumer_write_ask;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_addr;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data;
    logic [NUM_CONSUMERS-1:0]                consumer_write_get;

    // Memory side
    logic [NUM_CHANNELS-1:0]                 mem_read_ask;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_addr;
    logic [NUM_CHANNELS-1:0]                 mem_read_get;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data;
    logic [NUM_CHANNELS-1:0]                 mem_write_ask;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_addr;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data;
    logic [NUM_CHANNELS-1:0]                 mem_write_get;

    // Controller view
    modport slave (
        input  consumer_read_ask, consumer_read_addr,
        output consumer_read_get, consumer_read_data,
        input  consumer_write_ask, consumer_write_addr, consumer_write_data,
        output consumer_write_get,
        output mem_read_ask, mem_read_addr,
        input  mem_read_get, mem_read_data,
        output mem_write_ask, mem_write_addr, mem_write_data,
        input  mem_write_get
    );

    // Cores plus external memory view
    modport master (
        output consumer_read_ask, consumer_read_addr,
        input  consumer_read_get, consumer_read_data,
        output consumer_write_ask, consumer_write_addr, consumer_write_data,
        input  consumer_write_get,
        input  mem_read_ask, mem_read_addr,
        output mem_read_get, mem_read_data,
        input  mem_write_ask, mem_write_addr, mem_write_data,
        output mem_write_get
    );
endinterface

// File: rtl/mem_controller.sv
// Data-memory controller: arbitrates per-thread LSU requests onto a small
// number of memory channels. Each channel owns one consumer at a time and
// walks it through a request / wait / relay handshake. A rotating pointer
// decides where the next arbitration scan starts so no LSU is starved.
module mem_controller #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 4,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic             clk,
    input  logic             reset,
    mem_controller_if.slave  bus
);

    localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        READ_WAIT   = 3'd1,
        WRITE_WAIT  = 3'd2,
        READ_RELAY  = 3'd3,
        WRITE_RELAY = 3'd4
    } chan_state_t;

    // Per-channel state
    chan_state_t                              state_r [NUM_CHANNELS];
    logic [CW-1:0]                            owner_r [NUM_CHANNELS];

    // Shared arbitration state
    logic [NUM_CONSUMERS-1:0]                 claimed_r;
    logic [CW-1:0]                            rr_ptr_r;

    // Registered outputs
    logic [NUM_CONSUMERS-1:0]                 consumer_read_get_r;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data_r;
    logic [NUM_CONSUMERS-1:0]                 consumer_write_get_r;
    logic [NUM_CHANNELS-1:0]                  mem_read_ask_r;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_addr_r;
    logic [NUM_CHANNELS-1:0]                  mem_write_ask_r;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_addr_r;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data_r;

    // Arbitration results for the current cycle
    logic [NUM_CONSUMERS-1:0]                 asking_s;
    logic [NUM_CHANNELS-1:0]                  grant_s;
    logic [NUM_CHANNELS-1:0]                  grant_read_s;
    logic [CW-1:0]                            grant_idx_s [NUM_CHANNELS];
    logic                                     any_grant_s;
    logic [CW-1:0]                            next_rr_s;

    // Next consumer index in scan order, wrapping at NUM_CONSUMERS
    function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        if (v == CW'(NUM_CONSUMERS - 1)) begin
            r = {CW{1'b0}};
        end else begin
            r = v + {{(CW-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    assign bus.consumer_read_get  = consumer_read_get_r;
    assign bus.consumer_read_data = consumer_read_data_r;
    assign bus.consumer_write_get = consumer_write_get_r;
    assign bus.mem_read_ask       = mem_read_ask_r;
    assign bus.mem_read_addr      = mem_read_addr_r;
    // A read-only build ties the whole write port off
    assign bus.mem_write_ask  = (WRITE_ENABLE != 0) ? mem_write_ask_r  : {NUM_CHANNELS{1'b0}};
    assign bus.mem_write_addr = (WRITE_ENABLE != 0) ? mem_write_addr_r : {(NUM_CHANNELS*ADDR_BITS){1'b0}};
    assign bus.mem_write_data = (WRITE_ENABLE != 0) ? mem_write_data_r : {(NUM_CHANNELS*DATA_BITS){1'b0}};

    // Consumers presenting a request this controller will serve
    always_comb begin
        if (WRITE_ENABLE != 0) begin
            asking_s = bus.consumer_read_ask | bus.consumer_write_ask;
        end else begin
            asking_s = bus.consumer_read_ask;
        end
    end

    // Round-robin scan: idle channels pick, in channel order, the first
    // unclaimed asking consumer from rr_ptr onward; picks hide from later channels
    always_comb begin : scan_blk
        logic [NUM_CONSUMERS-1:0] taken_v;
        logic [CW-1:0]            idx_v;
        logic [CW-1:0]            pick_v;
        logic                     found_v;
        taken_v     = claimed_r;
        any_grant_s = 1'b0;
        next_rr_s   = rr_ptr_r;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            grant_s[c]      = 1'b0;
            grant_read_s[c] = 1'b0;
            grant_idx_s[c]  = {CW{1'b0}};
            found_v         = 1'b0;
            pick_v          = {CW{1'b0}};
            idx_v           = rr_ptr_r;
            if (state_r[c] == IDLE) begin
                for (int i = 0; i < NUM_CONSUMERS; i++) begin
                    if (!found_v && asking_s[idx_v] && !taken_v[idx_v]) begin
                        found_v = 1'b1;
                        pick_v  = idx_v;
                    end else begin
                        found_v = found_v;
                    end
                    idx_v = wrap_inc(idx_v);
                end
            end else begin
                found_v = 1'b0;
            end
            if (found_v) begin
                grant_s[c]      = 1'b1;
                grant_idx_s[c]  = pick_v;
                // read takes precedence when a consumer asks both ways
                grant_read_s[c] = bus.consumer_read_ask[pick_v];
                taken_v[pick_v] = 1'b1;
                any_grant_s     = 1'b1;
                // later channels claim later in scan order, so the last write wins
                next_rr_s       = wrap_inc(pick_v);
            end else begin
                grant_s[c] = 1'b0;
            end
        end
    end

    // Channel FSMs, claim bookkeeping, rotating pointer and all registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            claimed_r            <= {NUM_CONSUMERS{1'b0}};
            rr_ptr_r             <= {CW{1'b0}};
            consumer_read_get_r  <= {NUM_CONSUMERS{1'b0}};
            consumer_read_data_r <= {(NUM_CONSUMERS*DATA_BITS){1'b0}};
            consumer_write_get_r <= {NUM_CONSUMERS{1'b0}};
            mem_read_ask_r       <= {NUM_CHANNELS{1'b0}};
            mem_read_addr_r      <= {(NUM_CHANNELS*ADDR_BITS){1'b0}};
            mem_write_ask_r      <= {NUM_CHANNELS{1'b0}};
            mem_write_addr_r     <= {(NUM_CHANNELS*ADDR_BITS){1'b0}};
            mem_write_data_r     <= {(NUM_CHANNELS*DATA_BITS){1'b0}};
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_r[c] <= IDLE;
                owner_r[c] <= {CW{1'b0}};
            end
        end else begin
            if (any_grant_s) begin
                rr_ptr_r <= next_rr_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                case (state_r[c])
                    IDLE: begin
                        if (grant_s[c]) begin
                            claimed_r[grant_idx_s[c]] <= 1'b1;
                            owner_r[c]                <= grant_idx_s[c];
                            if (grant_read_s[c]) begin
                                mem_read_ask_r[c]  <= 1'b1;
                                mem_read_addr_r[c] <= bus.consumer_read_addr[grant_idx_s[c]];
                                state_r[c]         <= READ_WAIT;
                            end else begin
                                mem_write_ask_r[c]  <= 1'b1;
                                mem_write_addr_r[c] <= bus.consumer_write_addr[grant_idx_s[c]];
                                mem_write_data_r[c] <= bus.consumer_write_data[grant_idx_s[c]];
                                state_r[c]          <= WRITE_WAIT;
                            end
                        end else begin
                            state_r[c] <= IDLE;
                        end
                    end
                    READ_WAIT: begin
                        if (bus.mem_read_get[c]) begin
                            mem_read_ask_r[c]                <= 1'b0;
                            consumer_read_get_r[owner_r[c]]  <= 1'b1;
                            consumer_read_data_r[owner_r[c]] <= bus.mem_read_data[c];
                            state_r[c]                       <= READ_RELAY;
                        end else begin
                            state_r[c] <= READ_WAIT;
                        end
                    end
                    WRITE_WAIT: begin
                        if (bus.mem_write_get[c]) begin
                            mem_write_ask_r[c]               <= 1'b0;
                            consumer_write_get_r[owner_r[c]] <= 1'b1;
                            state_r[c]                       <= WRITE_RELAY;
                        end else begin
                            state_r[c] <= WRITE_WAIT;
                        end
                    end
                    READ_RELAY: begin
                        // hold get until the LSU lets go of its ask
                        if (!bus.consumer_read_ask[owner_r[c]]) begin
                            consumer_read_get_r[owner_r[c]] <= 1'b0;
                            claimed_r[owner_r[c]]           <= 1'b0;
                            state_r[c]                      <= IDLE;
                        end else begin
                            state_r[c] <= READ_RELAY;
                        end
                    end
                    WRITE_RELAY: begin
                        if (!bus.consumer_write_ask[owner_r[c]]) begin
                            consumer_write_get_r[owner_r[c]] <= 1'b0;
                            claimed_r[owner_r[c]]            <= 1'b0;
                            state_r[c]                       <= IDLE;
                        end else begin
                            state_r[c] <= WRITE_RELAY;
                        end
                    end
                    default: begin
                        mem_read_ask_r[c]  <= 1'b0;
                        mem_write_ask_r[c] <= 1'b0;
                        state_r[c]         <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller: a 4-channel read/write instance and a
// 1-channel read-only instance share one clock. A small behavioural memory
// answers each channel one cycle after its ask; LSUs optionally drop their
// ask as soon as they see get.
module tb_mem_controller;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_controller_if #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8), .NUM_CHANNELS(4)) a_if ();
    mem_controller_if #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8), .NUM_CHANNELS(1)) b_if ();

    mem_controller #(
        .ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8), .NUM_CHANNELS(4), .WRITE_ENABLE(1)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if.slave)
    );

    mem_controller #(
        .ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8), .NUM_CHANNELS(1), .WRITE_ENABLE(0)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if.slave)
    );

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic       hold_a;
    logic       auto_a;
    logic       auto_b;
    logic       reask0_b;
    int         tests_run    = 0;
    int         tests_failed = 0;

    // Count one comparison and report it when observed differs from expected
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock, then play memory and LSU for the next edge
    task automatic cycle();
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            if (a_if.mem_read_ask[c] && !a_if.mem_read_get[c] && !hold_a) begin
                a_if.mem_read_get[c]  = 1'b1;
                a_if.mem_read_data[c] = mem_a[a_if.mem_read_addr[c]];
            end else begin
                a_if.mem_read_get[c] = 1'b0;
            end
            if (a_if.mem_write_ask[c] && !a_if.mem_write_get[c]) begin
                a_if.mem_write_get[c] = 1'b1;
                mem_a[a_if.mem_write_addr[c]] = a_if.mem_write_data[c];
            end else begin
                a_if.mem_write_get[c] = 1'b0;
            end
        end
        if (b_if.mem_read_ask[0] && !b_if.mem_read_get[0]) begin
            b_if.mem_read_get[0]  = 1'b1;
            b_if.mem_read_data[0] = mem_b[b_if.mem_read_addr[0]];
        end else begin
            b_if.mem_read_get[0] = 1'b0;
        end
        for (int k = 0; k < 8; k++) begin
            if (auto_a && a_if.consumer_read_get[k])  a_if.consumer_read_ask[k]  = 1'b0;
            if (auto_a && a_if.consumer_write_get[k]) a_if.consumer_write_ask[k] = 1'b0;
            if (auto_b && b_if.consumer_read_get[k])  b_if.consumer_read_ask[k]  = 1'b0;
        end
        if (reask0_b && !b_if.consumer_read_get[0] && !b_if.consumer_read_ask[0])
            b_if.consumer_read_ask[0] = 1'b1;
    endtask

    // Run until instance A has no outstanding ask or get, within a budget
    task automatic drain(input string tag);
        int n;
        n = 0;
        while (((|a_if.consumer_read_get) || (|a_if.consumer_write_get) ||
                (|a_if.mem_read_ask) || (|a_if.mem_write_ask)) && n < 20) begin
            cycle();
            n++;
        end
        check_eq(tag, 64'(n < 20), 64'h1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   grant_log [$];
        logic [7:0] prev_get;
        logic [7:0] new_get;
        logic       wr_seen;
        logic       c2_read_seen;
        int   n;
        int   g0;
        int   g1;

        reset  = 1'b0;
        hold_a = 1'b0;
        auto_a = 1'b0;
        auto_b = 1'b0;
        reask0_b = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'(i) + 8'h95;
            mem_b[i] = 8'(i) + 8'h95;
        end
        a_if.consumer_read_ask   = '0; a_if.consumer_read_addr  = '0;
        a_if.consumer_write_ask  = '0; a_if.consumer_write_addr = '0;
        a_if.consumer_write_data = '0; a_if.mem_read_get        = '0;
        a_if.mem_read_data       = '0; a_if.mem_write_get       = '0;
        b_if.consumer_read_ask   = '0; b_if.consumer_read_addr  = '0;
        b_if.consumer_write_ask  = '0; b_if.consumer_write_addr = '0;
        b_if.consumer_write_data = '0; b_if.mem_read_get        = '0;
        b_if.mem_read_data       = '0; b_if.mem_write_get       = '0;

        // Reset state
        cycle();
        cycle();
        check_eq("rst_cons_rd_get", 64'(a_if.consumer_read_get), 64'h0);
        check_eq("rst_cons_wr_get", 64'(a_if.consumer_write_get), 64'h0);
        check_eq("rst_cons_rd_data", 64'(a_if.consumer_read_data), 64'h0);
        check_eq("rst_mem_rd_ask", 64'(a_if.mem_read_ask), 64'h0);
        check_eq("rst_mem_wr_ask", 64'(a_if.mem_write_ask), 64'h0);
        check_eq("rst_mem_wr_data", 64'(a_if.mem_write_data), 64'h0);
        reset = 1'b1;
        cycle();
        check_eq("idle_mem_rd_ask", 64'(a_if.mem_read_ask), 64'h0);
        check_eq("idle_mem_rd_addr", 64'(a_if.mem_read_addr), 64'h0);

        // Single read, ask held by hand to watch get stay up
        a_if.consumer_read_addr[0] = 8'h10;
        a_if.consumer_read_ask[0]  = 1'b1;
        cycle();
        check_eq("t1_mem_rd_ask", 64'(a_if.mem_read_ask), 64'h1);
        check_eq("t1_mem_rd_addr", 64'(a_if.mem_read_addr[0]), 64'h10);
        check_eq("t1_get_early", 64'(a_if.consumer_read_get), 64'h0);
        cycle();
        check_eq("t1_get", 64'(a_if.consumer_read_get), 64'h01);
        check_eq("t1_data", 64'(a_if.consumer_read_data[0]), 64'hA5);
        check_eq("t1_ask_dropped", 64'(a_if.mem_read_ask), 64'h0);
        cycle();
        check_eq("t1_get_held", 64'(a_if.consumer_read_get), 64'h01);
        a_if.consumer_read_ask[0] = 1'b0;
        cycle();
        check_eq("t1_get_released", 64'(a_if.consumer_read_get), 64'h0);
        check_eq("t1_data_kept", 64'(a_if.consumer_read_data[0]), 64'hA5);

        // Saturation: eight readers, four channels, scan starting at 0
        do_reset();
        auto_a = 1'b1;
        for (int k = 0; k < 8; k++) begin
            a_if.consumer_read_addr[k] = 8'h40 + 8'(k);
            a_if.consumer_read_ask[k]  = 1'b1;
        end
        cycle();
        check_eq("t2_ask_wave1", 64'(a_if.mem_read_ask), 64'hF);
        check_eq("t2_addr_wave1", 64'(a_if.mem_read_addr), 64'h43424140);
        cycle();
        check_eq("t2_get_wave1", 64'(a_if.consumer_read_get), 64'h0F);
        check_eq("t2_data3", 64'(a_if.consumer_read_data[3]), 64'hD8);
        cycle();
        check_eq("t2_gap_get", 64'(a_if.consumer_read_get), 64'h0);
        check_eq("t2_gap_ask", 64'(a_if.mem_read_ask), 64'h0);
        cycle();
        check_eq("t2_ask_wave2", 64'(a_if.mem_read_ask), 64'hF);
        check_eq("t2_addr_wave2", 64'(a_if.mem_read_addr), 64'h47464544);
        cycle();
        check_eq("t2_get_wave2", 64'(a_if.consumer_read_get), 64'hF0);
        check_eq("t2_data7", 64'(a_if.consumer_read_data[7]), 64'hDC);
        check_eq("t2_data0_kept", 64'(a_if.consumer_read_data[0]), 64'hD5);
        drain("t2_drain");

        // Write from consumer 3, then consumer 5 asks read and write together
        a_if.consumer_write_addr[3] = 8'h20;
        a_if.consumer_write_data[3] = 8'h5C;
        a_if.consumer_write_ask[3]  = 1'b1;
        cycle();
        check_eq("t4_wr_ask", 64'(a_if.mem_write_ask), 64'h1);
        check_eq("t4_wr_addr", 64'(a_if.mem_write_addr[0]), 64'h20);
        check_eq("t4_wr_data", 64'(a_if.mem_write_data[0]), 64'h5C);
        check_eq("t4_no_rd_ask", 64'(a_if.mem_read_ask), 64'h0);
        cycle();
        check_eq("t4_wr_get", 64'(a_if.consumer_write_get), 64'h08);
        check_eq("t4_wr_ask_drop", 64'(a_if.mem_write_ask), 64'h0);
        drain("t4_drain");
        a_if.consumer_read_addr[5]  = 8'h20;
        a_if.consumer_read_ask[5]   = 1'b1;
        a_if.consumer_write_addr[5] = 8'h21;
        a_if.consumer_write_data[5] = 8'h77;
        a_if.consumer_write_ask[5]  = 1'b1;
        cycle();
        check_eq("rw_read_wins", 64'({a_if.mem_read_ask, a_if.mem_write_ask}), 64'h10);
        cycle();
        check_eq("rw_read_back", 64'(a_if.consumer_read_data[5]), 64'h5C);
        cycle();
        cycle();
        check_eq("rw_write_next", 64'({a_if.mem_write_ask[0], a_if.mem_write_addr[0], a_if.mem_write_data[0]}), 64'h12177);
        drain("rw_drain");

        // Reset while a read waits on a stalled memory
        hold_a = 1'b1;
        a_if.consumer_read_addr[2] = 8'h33;
        a_if.consumer_read_ask[2]  = 1'b1;
        cycle();
        cycle();
        check_eq("t5_waiting", 64'(a_if.mem_read_ask), 64'h1);
        reset = 1'b0;
        cycle();
        reset  = 1'b1;
        hold_a = 1'b0;
        check_eq("t5_rst_ask", 64'(a_if.mem_read_ask), 64'h0);
        check_eq("t5_rst_get", 64'(a_if.consumer_read_get), 64'h0);
        check_eq("t5_rst_data", 64'(a_if.consumer_read_data), 64'h0);
        cycle();
        check_eq("t5_reclaim", 64'({a_if.mem_read_ask, a_if.mem_read_addr[0]}), 64'hF33 & 64'h133);
        cycle();
        check_eq("t5_get", 64'(a_if.consumer_read_get), 64'h04);
        check_eq("t5_data", 64'(a_if.consumer_read_data[2]), 64'hC8);
        drain("t5_drain");

        // Read-only single channel: fairness between 0 and 7, write asks ignored
        auto_b   = 1'b1;
        reask0_b = 1'b1;
        b_if.consumer_write_addr[2] = 8'h50;
        b_if.consumer_write_data[2] = 8'h99;
        b_if.consumer_write_ask[2]  = 1'b1;
        b_if.consumer_read_addr[0]  = 8'h01;
        b_if.consumer_read_addr[7]  = 8'h07;
        b_if.consumer_read_ask[0]   = 1'b1;
        b_if.consumer_read_ask[7]   = 1'b1;
        prev_get     = 8'h00;
        wr_seen      = 1'b0;
        c2_read_seen = 1'b0;
        n = 0;
        while (grant_log.size() < 2 && n < 30) begin
            cycle();
            n++;
            wr_seen = wr_seen | (|b_if.mem_write_ask) | (|b_if.consumer_write_get) |
                      (|b_if.mem_write_addr) | (|b_if.mem_write_data);
            c2_read_seen = c2_read_seen | b_if.consumer_read_get[2];
            new_get  = b_if.consumer_read_get & ~prev_get;
            prev_get = b_if.consumer_read_get;
            for (int k = 0; k < 8; k++) begin
                if (new_get[k]) grant_log.push_back(k);
            end
        end
        g0 = (grant_log.size() > 0) ? grant_log[0] : -1;
        g1 = (grant_log.size() > 1) ? grant_log[1] : -1;
        check_eq("t3_two_grants", 64'(n < 30), 64'h1);
        check_eq("t3_first_grant", 64'(g0), 64'h0);
        check_eq("t3_second_grant", 64'(g1), 64'h7);
        check_eq("t3_data7", 64'(b_if.consumer_read_data[7]), 64'h9C);
        check_eq("t6_write_quiet", 64'(wr_seen), 64'h0);
        check_eq("t6_no_c2_get", 64'(c2_read_seen), 64'h0);
        reask0_b = 1'b0;
        b_if.consumer_read_ask = '0;
        for (int i = 0; i < 4; i++) cycle();
        check_eq("t6_idle_after", 64'({b_if.mem_read_ask, b_if.mem_write_ask, b_if.consumer_write_get}), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
